// File: rtl/lru_pkg.sv
// -----------------------------------------------------------------------------
// lru_pkg
// Shared definitions for the LRU key tracker.
//   lru_state_e : tracker FSM states (IDLE, ACCESS, HOLD)
//   EMPTY_IDX   : key index stored in an unused stack entry
//   MAX_KEYS    : widest key vector the helpers accept
//   lowest_key  : index (1-based) of the lowest set bit, 0 when none is set
// No ports; imported by lru_stack and lru_tracker.
// -----------------------------------------------------------------------------
package lru_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2
  } lru_state_e;

  localparam int MAX_KEYS  = 15;
  localparam int EMPTY_IDX = 0;

  // Lowest index wins, so simultaneous presses resolve to the smallest key.
  function automatic logic [3:0] lowest_key(input logic [MAX_KEYS-1:0] req);
    lowest_key = 4'd0;
    for (int i = MAX_KEYS - 1; i >= 0; i--) begin
      if (req[i]) lowest_key = 4'(i + 1);
    end
  endfunction

endpackage

// File: rtl/lru_stack.sv
// -----------------------------------------------------------------------------
// lru_stack
// True-LRU recency stack; entry 0 is the most recently used key.
// Parameters: NUM_KEYS (keys tracked), DEPTH (stack entries).
// Ports:
//   timedClk    in   block clock
//   rst         in   synchronous active-high reset
//   access      in   one-cycle strobe: apply sel to the stack this edge
//   sel         in   [IDX_W] key index to access (never 0 while access is high)
//   entries     out  [DEPTH][IDX_W] registered stack contents
//   count       out  [CNT_W] number of valid entries
//   hit         out  pulse: the last access found its key resident
//   evict_valid out  pulse: an entry was dropped by the last access
//   evict_idx   out  [IDX_W] dropped key while evict_valid, else 0
// -----------------------------------------------------------------------------
module lru_stack
  import lru_pkg::*;
#(
  parameter int NUM_KEYS = 4,
  parameter int DEPTH    = 3,
  localparam int IDX_W   = $clog2(NUM_KEYS + 1),
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                        timedClk,
  input  logic                        rst,
  input  logic                        access,
  input  logic [IDX_W-1:0]            sel,
  output logic [DEPTH-1:0][IDX_W-1:0] entries,
  output logic [CNT_W-1:0]            count,
  output logic                        hit,
  output logic                        evict_valid,
  output logic [IDX_W-1:0]            evict_idx
);

  logic                        found;
  int                          pos;
  int                          limit;
  logic                        is_full;
  logic [DEPTH-1:0][IDX_W-1:0] nxt;

  // Search, then shift every entry at or above "limit" down one slot and
  // insert sel on top. limit is the hit position, or the first empty slot
  // on a miss, or the last slot (which falls off) when the stack is full.
  always_comb begin
    found = 1'b0;
    pos   = 0;
    for (int p = 0; p < DEPTH; p++) begin
      if (!found && (p < int'(count)) && (entries[p] == sel)) begin
        found = 1'b1;
        pos   = p;
      end
    end
    is_full = (int'(count) == DEPTH);
    if (found)        limit = pos;
    else if (is_full) limit = DEPTH - 1;
    else              limit = int'(count);
    nxt    = entries;
    nxt[0] = sel;
    for (int i = 1; i < DEPTH; i++) begin
      if (i <= limit) nxt[i] = entries[i-1];
    end
  end

  always_ff @(posedge timedClk) begin
    if (rst) begin
      entries     <= '0;
      count       <= '0;
      hit         <= 1'b0;
      evict_valid <= 1'b0;
      evict_idx   <= IDX_W'(EMPTY_IDX);
    end else if (access) begin
      entries     <= nxt;
      if (!found && !is_full) count <= count + 1'b1;
      hit         <= found;
      evict_valid <= !found && is_full;
      evict_idx   <= (!found && is_full) ? entries[DEPTH-1] : IDX_W'(EMPTY_IDX);
    end else begin
      hit         <= 1'b0;
      evict_valid <= 1'b0;
      evict_idx   <= IDX_W'(EMPTY_IDX);
    end
  end

endmodule

// File: rtl/lru_tracker.sv
// -----------------------------------------------------------------------------
// lru_tracker
// LRU tracker for NUM_KEYS push-buttons. Each press (rising from all-released)
// produces exactly one access to an LRU stack of DEPTH entries; one LED per
// resident key. Optional macro LRU_STATS_EN adds saturating hit/miss counters.
// Parameters: NUM_KEYS (2..15), DEPTH (1..NUM_KEYS).
// Ports:
//   timedClk    in   divided block clock
//   rst         in   synchronous active-high reset
//   key_req     in   [NUM_KEYS] button levels, bit k = key k+1
//   leds        out  [NUM_KEYS] bit k high iff key k+1 is resident
//   mru_idx     out  [IDX_W] most recent key, 0 when empty
//   lru_idx     out  [IDX_W] least recent key, 0 when empty
//   count       out  [CNT_W] valid entries
//   full        out  count == DEPTH
//   hit         out  pulse: last access was a hit
//   evict_valid out  pulse: an entry was dropped
//   evict_idx   out  [IDX_W] dropped key while evict_valid, else 0
//   hit_cnt     out  [16] saturating hit count   (LRU_STATS_EN only)
//   miss_cnt    out  [16] saturating miss count  (LRU_STATS_EN only)
//   state_dbg   out  [2] current FSM state (IDLE=0, ACCESS=1, HOLD=2)
// -----------------------------------------------------------------------------
module lru_tracker
  import lru_pkg::*;
#(
  parameter int NUM_KEYS = 4,
  parameter int DEPTH    = 3,
  localparam int IDX_W   = $clog2(NUM_KEYS + 1),
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                timedClk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_req,
  output logic [NUM_KEYS-1:0] leds,
  output logic [IDX_W-1:0]    mru_idx,
  output logic [IDX_W-1:0]    lru_idx,
  output logic [CNT_W-1:0]    count,
  output logic                full,
  output logic                hit,
  output logic                evict_valid,
  output logic [IDX_W-1:0]    evict_idx,
`ifdef LRU_STATS_EN
  output logic [15:0]         hit_cnt,
  output logic [15:0]         miss_cnt,
`endif
  output logic [1:0]          state_dbg
);

  if (NUM_KEYS < 2 || NUM_KEYS > MAX_KEYS || DEPTH < 1 || DEPTH > NUM_KEYS) begin : g_bad_param
    $error("lru_tracker: NUM_KEYS must be 2..15 and DEPTH 1..NUM_KEYS");
  end

  localparam logic [1:0] ST_IDLE   = 2'(IDLE);
  localparam logic [1:0] ST_ACCESS = 2'(ACCESS);
  localparam logic [1:0] ST_HOLD   = 2'(HOLD);

  logic [1:0]                  state;
  logic [IDX_W-1:0]            sel_q;
  logic                        access_q;
  logic [MAX_KEYS-1:0]         req_ext;
  logic [IDX_W-1:0]            next_sel;
  logic [DEPTH-1:0][IDX_W-1:0] entries;

  always_comb begin
    req_ext                 = '0;
    req_ext[NUM_KEYS-1:0]   = key_req;
  end
  assign next_sel = IDX_W'(lowest_key(req_ext));

  // Handshake to the stack: access_q is a one-cycle valid carrying sel_q;
  // the stack is always ready and consumes it on the same edge. The strobe
  // is registered out of ACCESS, so a reset during ACCESS kills it.
  always_ff @(posedge timedClk) begin
    if (rst) begin
      state    <= ST_IDLE;
      sel_q    <= '0;
      access_q <= 1'b0;
    end else begin
      access_q <= (state == ST_ACCESS);
      case (state)
        ST_IDLE: begin
          if (|key_req) begin
            sel_q <= next_sel;
            state <= ST_ACCESS;
          end
        end
        ST_ACCESS: state <= ST_HOLD;
        ST_HOLD:   if (key_req == '0) state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  assign state_dbg = state;

  lru_stack #(
    .NUM_KEYS (NUM_KEYS),
    .DEPTH    (DEPTH)
  ) u_stack (
    .timedClk    (timedClk),
    .rst         (rst),
    .access      (access_q),
    .sel         (sel_q),
    .entries     (entries),
    .count       (count),
    .hit         (hit),
    .evict_valid (evict_valid),
    .evict_idx   (evict_idx)
  );

  // Empty entries hold 0 and k+1 is never 0, so they cannot light an LED.
  always_comb begin
    leds = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (entries[i] == IDX_W'(k + 1)) leds[k] = 1'b1;
      end
    end
  end

  always_comb begin
    lru_idx = IDX_W'(EMPTY_IDX);
    for (int i = 0; i < DEPTH; i++) begin
      if (int'(count) == i + 1) lru_idx = entries[i];
    end
  end

  assign mru_idx = entries[0];
  assign full    = (int'(count) == DEPTH);

`ifdef LRU_STATS_EN
  logic        access_d;
  logic [15:0] hit_cnt_r;
  logic [15:0] miss_cnt_r;

  // The hit flag of an access is registered alongside the stack, so the
  // counters classify it one cycle after the strobe.
  always_ff @(posedge timedClk) begin
    if (rst) begin
      access_d   <= 1'b0;
      hit_cnt_r  <= '0;
      miss_cnt_r <= '0;
    end else begin
      access_d <= access_q;
      if (access_d) begin
        if (hit) begin
          if (hit_cnt_r != 16'hFFFF) hit_cnt_r <= hit_cnt_r + 16'd1;
        end else begin
          if (miss_cnt_r != 16'hFFFF) miss_cnt_r <= miss_cnt_r + 16'd1;
        end
      end
    end
  end

  assign hit_cnt  = hit_cnt_r;
  assign miss_cnt = miss_cnt_r;
`endif

endmodule
